// File: rtl/difftest_log_event_if.sv
// Dump/clear request and log-record bundle for difftest_log_event.
// The master drives requests and consumes records; the slave is the logger.
interface difftest_log_event_if #(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SEQ_W   = 16
);
  logic               dump_req;
  logic               clear_req;
  logic               out_valid;
  logic [INDEX_W-1:0] out_index;
  logic [CNT_W-1:0]   out_value;
  logic [CNT_W-1:0]   out_delta;
  logic               out_wrap;
  logic [SEQ_W-1:0]   out_seq;

  modport master (
    output dump_req, clear_req,
    input  out_valid, out_index, out_value, out_delta, out_wrap, out_seq
  );

  modport slave (
    input  dump_req, clear_req,
    output out_valid, out_index, out_value, out_delta, out_wrap, out_seq
  );
endinterface

// File: rtl/difftest_log_event.sv
// Per-event performance-log sink: samples a free-running counter and, on a dump
// request, emits one registered record with value, delta, wrap flag and sequence.
module difftest_log_event #(
  parameter              NAME    = "event",
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned SEQ_W   = 16
) (
  input  logic               clk,
  input  logic [INDEX_W-1:0] index,
  input  logic [CNT_W-1:0]   counter,
  input  logic               rst,
  difftest_log_event_if.slave bus
);

  // NAME only tags the instance in logs; it has no effect on the datapath.
  if ($bits(NAME) == 0) begin : gUntagged
  end

  logic               armedQ;
  logic [CNT_W-1:0]   prevQ;
  logic [CNT_W-1:0]   baselineQ;
  logic               wrapSeenQ;
  logic               wrapSeenD;
  logic [SEQ_W-1:0]   seqQ;

  logic               validQ;
  logic [INDEX_W-1:0] indexQ;
  logic [CNT_W-1:0]   valueQ;
  logic [CNT_W-1:0]   deltaQ;
  logic               wrapQ;
  logic [SEQ_W-1:0]   outSeqQ;

  logic               decNow;
  logic               rebase;
  logic [CNT_W-1:0]   delta;

  // armedQ masks the first post-reset compare against the zeroed prevQ.
  always_comb begin
    decNow    = armedQ && (counter < prevQ);
    rebase    = bus.dump_req || bus.clear_req;
    delta     = counter - baselineQ;
    wrapSeenD = wrapSeenQ;
    if (rebase) begin
      wrapSeenD = 1'b0;
    end else if (decNow) begin
      wrapSeenD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armedQ    <= 1'b0;
      prevQ     <= '0;
      baselineQ <= '0;
      wrapSeenQ <= 1'b0;
      seqQ      <= '0;
    end else begin
      armedQ    <= 1'b1;
      prevQ     <= counter;
      wrapSeenQ <= wrapSeenD;
      if (rebase) begin
        baselineQ <= counter;
      end
      if (bus.dump_req) begin
        seqQ <= seqQ + SEQ_W'(1);
      end
    end
  end

  // Record fields hold their last values between dumps; only validQ pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validQ  <= 1'b0;
      indexQ  <= '0;
      valueQ  <= '0;
      deltaQ  <= '0;
      wrapQ   <= 1'b0;
      outSeqQ <= '0;
    end else begin
      validQ <= bus.dump_req;
      if (bus.dump_req) begin
        indexQ  <= index;
        valueQ  <= counter;
        deltaQ  <= delta;
        wrapQ   <= wrapSeenQ | decNow;
        outSeqQ <= seqQ;
      end
    end
  end

  assign bus.out_valid = validQ;
  assign bus.out_index = indexQ;
  assign bus.out_value = valueQ;
  assign bus.out_delta = deltaQ;
  assign bus.out_wrap  = wrapQ;
  assign bus.out_seq   = outSeqQ;

endmodule

// File: tb/tb_difftest_log_event.sv
// Directed and randomized checks of difftest_log_event against a history-based
// model: wrap is any decrease in the sample history since the last baseline.
module tb_difftest_log_event;
  localparam int unsigned IW = 8;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] index = '0;
  logic [CW-1:0] counter = '0;

  difftest_log_event_if #(.INDEX_W(IW), .CNT_W(CW), .SEQ_W(SW)) bus ();

  difftest_log_event #(
    .NAME   ("event"),
    .INDEX_W(IW),
    .CNT_W  (CW),
    .SEQ_W  (SW)
  ) dut (
    .clk    (clk),
    .index  (index),
    .counter(counter),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail    = 0;

  // Reference model state.
  logic [CW-1:0] hist[$];
  logic [CW-1:0] mBase;
  logic [SW-1:0] mSeqNext;
  logic          mValid;
  logic [IW-1:0] mIndex;
  logic [CW-1:0] mValue;
  logic [CW-1:0] mDelta;
  logic          mWrap;
  logic [SW-1:0] mSeq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRecord(input string tag);
    check({tag, ".valid"}, 64'(bus.out_valid), 64'(mValid));
    check({tag, ".index"}, 64'(bus.out_index), 64'(mIndex));
    check({tag, ".value"}, 64'(bus.out_value), 64'(mValue));
    check({tag, ".delta"}, 64'(bus.out_delta), 64'(mDelta));
    check({tag, ".wrap"},  64'(bus.out_wrap),  64'(mWrap));
    check({tag, ".seq"},   64'(bus.out_seq),   64'(mSeq));
  endtask

  task automatic modelReset();
    hist.delete();
    mBase    = '0;
    mSeqNext = '0;
    mValid   = 1'b0;
    mIndex   = '0;
    mValue   = '0;
    mDelta   = '0;
    mWrap    = 1'b0;
    mSeq     = '0;
  endtask

  task automatic modelEdge(input logic [CW-1:0] cnt, input logic [IW-1:0] idx,
                           input bit dump, input bit clear);
    bit wrap;
    hist.push_back(cnt);
    mValid = 1'b0;
    if (dump) begin
      wrap = 1'b0;
      for (int i = 1; i < hist.size(); i++) begin
        if (hist[i] < hist[i-1]) wrap = 1'b1;
      end
      mValid   = 1'b1;
      mIndex   = idx;
      mValue   = cnt;
      mDelta   = cnt - mBase;
      mWrap    = wrap;
      mSeq     = mSeqNext;
      mSeqNext = mSeqNext + 1'b1;
    end
    if (dump || clear) begin
      mBase = cnt;
      hist.delete();
      hist.push_back(cnt);
    end
  endtask

  task automatic step(input string tag, input logic [CW-1:0] cnt, input bit dump,
                      input bit clear);
    counter       = cnt;
    bus.dump_req  = dump;
    bus.clear_req = clear;
    @(posedge clk);
    modelEdge(cnt, index, dump, clear);
    #1;
    checkRecord(tag);
    bus.dump_req  = 1'b0;
    bus.clear_req = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    #1;
    modelReset();
    checkRecord("reset");
    @(posedge clk);
    #1;
    checkRecord("reset_held");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [CW-1:0] cnt;
    bus.dump_req  = 1'b0;
    bus.clear_req = 1'b0;
    modelReset();
    #2;
    checkRecord("por");
    doReset();

    // Ramp 0..10, dump at 10.
    for (int v = 0; v <= 10; v++) step("t1", CW'(v), v == 10, 1'b0);
    check("t1_value", 64'(bus.out_value), 64'd10);
    check("t1_delta", 64'(bus.out_delta), 64'd10);
    check("t1_seq",   64'(bus.out_seq),   64'd0);
    // Ramp to 25, dump; valid must drop the following cycle.
    for (int v = 11; v <= 25; v++) step("t2", CW'(v), v == 25, 1'b0);
    check("t2_delta", 64'(bus.out_delta), 64'd15);
    check("t2_seq",   64'(bus.out_seq),   64'd1);
    step("t2_after", 32'd26, 1'b0, 1'b0);
    check("t2_pulse", 64'(bus.out_valid), 64'd0);

    // Wrap from a fresh baseline of 0.
    doReset();
    step("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0);
    step("t3b", 32'h0000_0003, 1'b1, 1'b0);
    check("t3_delta", 64'(bus.out_delta), 64'd3);
    check("t3_wrap",  64'(bus.out_wrap),  64'd1);
    for (int v = 4; v <= 7; v++) step("t3c", CW'(v), v == 7, 1'b0);
    check("t3_delta2", 64'(bus.out_delta), 64'd4);
    check("t3_wrap2",  64'(bus.out_wrap),  64'd0);

    // Clear then dump: no record for the clear, seq advances by one.
    step("t4_clr", 32'd100, 1'b0, 1'b1);
    check("t4_noval", 64'(bus.out_valid), 64'd0);
    for (int v = 110; v <= 130; v += 10) step("t4", CW'(v), v == 130, 1'b0);
    check("t4_delta", 64'(bus.out_delta), 64'd30);
    check("t4_seq",   64'(bus.out_seq),   64'd2);

    // Dump and clear together behave as a dump.
    step("t5a", 32'd40, 1'b1, 1'b0);
    step("t5b", 32'd50, 1'b1, 1'b1);
    check("t5_delta", 64'(bus.out_delta), 64'd10);
    step("t5c", 32'd55, 1'b1, 1'b0);
    check("t5_delta2", 64'(bus.out_delta), 64'd5);

    // Asynchronous reset mid-cycle with a dump pending.
    counter      = 32'd60;
    bus.dump_req = 1'b1;
    @(posedge clk);
    modelEdge(32'd60, index, 1'b1, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    modelReset();
    checkRecord("t6_async");
    @(posedge clk);
    #1;
    checkRecord("t6_held");
    @(negedge clk);
    rst          = 1'b1;
    bus.dump_req = 1'b0;
    for (int v = 0; v <= 4; v++) step("t6", CW'(v), v == 4, 1'b0);
    check("t6_seq",   64'(bus.out_seq),   64'd0);
    check("t6_delta", 64'(bus.out_delta), 64'd4);
    check("t6_wrap",  64'(bus.out_wrap),  64'd0);

    // Randomized traffic starting near the wrap point.
    cnt = 32'hFFFF_FF00;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r == 99) begin
        doReset();
      end else begin
        if (r < 5) cnt = $urandom;
        else cnt = cnt + CW'($urandom_range(0, 50));
        index = IW'($urandom);
        step("rand", cnt, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end
endmodule

// File: doc/difftest_log_event.md
Name: difftest_log_event

Overview:
Per-event performance-log sink. It samples one free-running 32-bit event counter every cycle and, on a dump request, emits a one-cycle log record. The record carries the event index, the current value, the delta since the previous dump or clear, a wrap/decrease flag and a sequence number. One instance is placed next to each PERF counter in DIFFTEST builds. The counter is wired by position as (clock, index, counter) ahead of the added control ports.

Parameters:
NAME, "event", string event tag; not used in datapath logic and carried for log identification only.
INDEX_W, 8, width of the event index.
CNT_W, 32, width of the event counter and of the value/delta outputs.
SEQ_W, 16, width of the dump sequence number.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
index  in  INDEX_W  static event index; tied to 0 by current users.
counter  in  CNT_W  event counter value; expected non-decreasing except for wrap.
dump_req  in  1  request a log record this cycle.
clear_req  in  1  re-baseline without emitting a record.
out_valid  out  1  one-cycle pulse marking a record.
out_index  out  INDEX_W  index captured at the dump edge.
out_value  out  CNT_W  counter value at the dump edge.
out_delta  out  CNT_W  counter minus baseline, modulo 2^CNT_W.
out_wrap  out  1  counter decreased at least once since the last baseline.
out_seq  out  SEQ_W  dump number, starting at 0.

Behaviour:
- Reset (rst low, asynchronous): every output is 0. Internal registers baseline, prev_q, wrap_seen and seq are 0.
- Every cycle: prev_q <= counter.
- Decrease detect: dec_now = (counter < prev_q), unsigned compare. It is suppressed on the first cycle after reset so that the reset value of prev_q cannot trigger it.
- Sticky flag: wrap_seen <= 1 on dec_now when no dump or clear is taken that cycle.
- Dump (dump_req=1 at an edge), registered outputs, latency 1 cycle:
  - out_valid = 1.
  - out_index = index.
  - out_value = counter.
  - out_delta = counter - baseline, truncated to CNT_W.
  - out_wrap = wrap_seen | dec_now.
  - out_seq = seq.
  - State updates: baseline <= counter, wrap_seen <= 0, seq <= seq + 1 (wraps at 2^SEQ_W).
- Clear (clear_req=1 without dump_req): baseline <= counter, wrap_seen <= 0. No record is emitted and seq is unchanged.
- dump_req and clear_req together: treated as a dump; the clear is redundant.
- When no dump is taken: out_valid = 0. The other outputs hold their last record values.
- Back-to-back dumps: one record per cycle. Each delta equals the counter change over that single cycle.
- Counter wrap, e.g. 0xFFFFFFFE to 0x00000003: out_delta is the modular difference (5) and out_wrap = 1.
- Reset asserted mid-operation: immediate return to the reset state; any pending record is lost.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then counter steps 0..10 with one per cycle; dump_req when counter=10 -> next cycle out_valid=1, out_value=10, out_delta=10, out_wrap=0, out_seq=0.
2. Continue to counter=25 and dump again -> out_value=25, out_delta=15, out_seq=1; out_valid is high for exactly one cycle.
3. baseline=0x00000000 (fresh after reset); drive counter=0xFFFFFFFE, then 0x00000003; dump -> out_delta=3, out_wrap=1. Next dump at counter=0x00000007 -> out_delta=4, out_wrap=0.
4. clear_req at counter=100, then dump at counter=130 -> out_delta=30; no out_valid pulse for the clear; out_seq advances by only 1.
5. dump_req and clear_req together at counter=50 after a baseline of 40 -> out_delta=10. A following dump at 55 -> out_delta=5.
6. Assert rst low asynchronously, mid-cycle, while dump_req=1 -> all outputs 0 immediately. After release, the first dump at counter=4 gives out_seq=0, out_delta=4, out_wrap=0.
